eqn_ckt_sequencer: RTL and testbench

Self-checking controller that drives the three inputs of the equation circuit (Y = A·B·C + A·B + A·C) through all eight combinations and samples Y after a programmable settle time. It compares each sample against an expected truth table, then reports an error count, the first failing index and a pass flag. It sits beside the combinational equation datapath as its built-in exerciser and replaces the hand-written `#100` stimulus sequence with a clocked, start/done-handshaked run.

---
 rtl/eqn_ckt_sequencer.sv | 127 ++++++++++++
 tb/tb_eqn_ckt_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eqn_ckt_sequencer.sv
// eqn_ckt_sequencer: built-in exerciser for the equation circuit
// Y = A&B&C | A&B | A&C. Walks {A,B,C} through indices 0..7, holds each
// vector for SETTLE+1 cycles, samples Y against EXP and reports
// err_cnt / first_fail / pass with a start/done handshake.
// Optional macro EQN_SEQ_TT_CAPTURE_EN: capture the observed truth table
// on TT. When it is undefined, TT is tied to zero.
`timescale 1ns/1ps
module eqn_ckt_sequencer #(
    parameter int unsigned SETTLE = 2,
    parameter logic [7:0]  EXP    = 8'hE0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic [7:0] TT
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] abc;
    logic       mismatch;

    assign mismatch  = (Y != EXP[idx]);
    assign {A, B, C} = abc;
    assign done      = (state == S_DONE);

    // Main sequencer: vector stepping, settle counting, sampling and result tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            abc        <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    abc <= '0;
                    if (start) begin
                        idx        <= '0;
                        cnt        <= CNT_LOAD;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    abc <= idx;
                    if (cnt == 4'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 4'd1;
                        if (err_cnt == 4'd0) begin
                            first_fail <= idx;
                        end
                    end
                    if (idx == 3'd7) begin
                        state <= S_DONE;
                    end else begin
                        // Drive the next vector on this same edge so each index
                        // gets exactly SETTLE+1 cycles before its sample edge.
                        idx   <= idx + 3'd1;
                        abc   <= idx + 3'd1;
                        cnt   <= CNT_LOAD;
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    pass  <= (err_cnt == 4'd0);
                    busy  <= 1'b0;
                    abc   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef EQN_SEQ_TT_CAPTURE_EN
    logic [7:0] tt_q;

    // Observed truth table: cleared on reset or accepted start, one bit per sample
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q <= '0;
        end else if (state == S_IDLE && start) begin
            tt_q <= '0;
        end else if (state == S_SAMPLE) begin
            tt_q[idx] <= Y;
        end
    end

    assign TT = tt_q;
`else
    assign TT = '0;
`endif

endmodule

// File: tb/tb_eqn_ckt_sequencer.sv
// tb_eqn_ckt_sequencer: randomized self-checking bench for eqn_ckt_sequencer.
// A behavioural model derives every output from the cycle count since start
// and the Y truth table presented to the DUT; literal checks pin the
// headline scenarios. TT expectations follow EQN_SEQ_TT_CAPTURE_EN.
`timescale 1ns/1ps
module tb_eqn_ckt_sequencer;

    localparam int unsigned S       = 2;
    localparam logic [7:0]  EXP_TB  = 8'hE0;
    localparam int          RUN_LEN = 8 * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       Y;
    logic       A, B, C;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [2:0] first_fail;
    logic [7:0] TT;

    logic [7:0] ytab;

    int n_pass  = 0;
    int n_total = 0;

    eqn_ckt_sequencer #(.SETTLE(S), .EXP(EXP_TB)) dut (
        .clk(clk), .rst(rst), .start(start), .Y(Y),
        .A(A), .B(B), .C(C),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .TT(TT)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: Y is a combinational lookup of {A,B,C}
    always_comb Y = ytab[{A, B, C}];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [7:0] real_table();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            logic a, b, c;
            a = ((i >> 2) & 1) != 0;
            b = ((i >> 1) & 1) != 0;
            c = (i & 1) != 0;
            t[i] = (a & b & c) | (a & b) | (a & c);
        end
        return t;
    endfunction

    // Inputs as seen by the DUT at each rising edge
    logic s_rst = 1'b1;
    logic s_start = 1'b0;
    initial forever begin
        @(posedge clk);
        s_rst   = rst;
        s_start = start;
    end

    // Behavioural model and per-cycle comparison
    logic chk_en = 1'b0;
    initial begin : model
        bit         running;
        int         t;
        logic [7:0] m_tab;
        int         r_err;
        int         r_ff;
        logic [7:0] r_tt;
        logic       r_pass;
        int         e_abc;
        logic [7:0] e_tt;
        running = 0; t = 0; m_tab = '0;
        r_err = 0; r_ff = 0; r_tt = '0; r_pass = 0;
        forever begin
            @(negedge clk);
            if (s_rst) begin
                running = 0; t = 0;
                r_err = 0; r_ff = 0; r_tt = '0; r_pass = 0;
            end else if (running) begin
                t++;
                if (t == RUN_LEN + 1) begin
                    running = 0;
                    r_pass  = (r_err == 0);
                end
            end else if (s_start) begin
                running = 1; t = 0; m_tab = ytab;
                r_err = 0; r_ff = 0; r_tt = '0; r_pass = 0;
            end
            if (running) begin
                r_err = 0; r_ff = 0; r_tt = '0;
                for (int i = 0; i < 8; i++) begin
                    if ((i + 1) * (S + 1) <= t) begin
                        if (m_tab[i] != EXP_TB[i]) begin
                            if (r_err == 0) r_ff = i;
                            r_err++;
                        end
                        r_tt[i] = m_tab[i];
                    end
                end
            end
            e_abc = running ? ((t / (S + 1)) > 7 ? 7 : (t / (S + 1))) : 0;
`ifdef EQN_SEQ_TT_CAPTURE_EN
            e_tt = r_tt;
`else
            e_tt = 8'h00;
`endif
            if (chk_en) begin
                chk("abc", 32'({A, B, C}), 32'(e_abc));
                chk("busy", 32'(busy), 32'(running));
                chk("done", 32'(done), 32'(running && t == RUN_LEN));
                chk("pass", 32'(pass), 32'(r_pass));
                chk("err_cnt", 32'(err_cnt), 32'(r_err));
                chk("first_fail", 32'(first_fail), 32'(r_ff));
                chk("TT", 32'(TT), 32'(e_tt));
            end
        end
    end

    // One run: optional extra start pulse at edge start_again, optional reset at edge rst_at
    task automatic do_run(input int start_again, input int rst_at, output int de);
        de = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            @(negedge clk);
            start = (e == start_again);
            rst   = (e == rst_at);
            if (done) begin
                de = e;
                break;
            end
            if (rst_at > 0 && e == rst_at + 1) break;
        end
        start = 1'b0;
        rst   = 1'b0;
        if (de < 0 && rst_at == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int de;
        int d1, d2;
        rst = 1'b1; start = 1'b0; ytab = real_table();
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        rst = 1'b0;

        // Run 1: correct datapath
        chk("model_real_table", 32'(ytab), 32'h0000_00E0);
        do_run(0, 0, de);
        chk("run1_done_edge", 32'(de), 32'd25);
        @(posedge clk); #1;
        chk("run1_pass", 32'(pass), 32'd1);
        chk("run1_err", 32'(err_cnt), 32'd0);
`ifdef EQN_SEQ_TT_CAPTURE_EN
        chk("run1_tt", 32'(TT), 32'h0000_00E0);
`else
        chk("run1_tt", 32'(TT), 32'h0);
`endif

        // Run 2: Y stuck at 0
        ytab = 8'h00;
        do_run(0, 0, de);
        @(posedge clk); #1;
        chk("run2_err", 32'(err_cnt), 32'd3);
        chk("run2_ff", 32'(first_fail), 32'd5);
        chk("run2_pass", 32'(pass), 32'd0);
        chk("run2_tt", 32'(TT), 32'h0);

        // Run 3: Y stuck at 1
        ytab = 8'hFF;
        do_run(0, 0, de);
        @(posedge clk); #1;
        chk("run3_err", 32'(err_cnt), 32'd5);
        chk("run3_ff", 32'(first_fail), 32'd0);
        chk("run3_pass", 32'(pass), 32'd0);
`ifdef EQN_SEQ_TT_CAPTURE_EN
        chk("run3_tt", 32'(TT), 32'h0000_00FF);
`else
        chk("run3_tt", 32'(TT), 32'h0);
`endif

        // Run 4: start pulsed again while busy
        ytab = real_table();
        do_run(10, 0, de);
        chk("run4_done_edge", 32'(de), 32'd25);
        @(posedge clk); #1;
        chk("run4_pass", 32'(pass), 32'd1);

        // Run 5: reset while idx=4, with errors already accumulated
        ytab = 8'hFF;
        do_run(0, 13, de);
        chk("run5_abc", 32'({A, B, C}), 32'd0);
        chk("run5_busy", 32'(busy), 32'd0);
        chk("run5_err", 32'(err_cnt), 32'd0);
        chk("run5_done", 32'(done), 32'd0);
        ytab = real_table();
        do_run(0, 0, de);
        chk("run5b_done_edge", 32'(de), 32'd25);
        @(posedge clk); #1;
        chk("run5b_pass", 32'(pass), 32'd1);

        // Start held high: back-to-back runs with one idle cycle between
        d1 = -1; d2 = -1;
        @(posedge clk); #1 start = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = e;
                else begin
                    d2 = e;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("held_gap", 32'(d2 - d1), 32'(RUN_LEN + 2));
        @(posedge clk); #1;

        // Randomized truth tables
        for (int r = 0; r < 8; r++) begin
            ytab = 8'($urandom);
            do_run(0, 0, de);
            chk("rand_done_edge", 32'(de), 32'(RUN_LEN + 1));
            @(posedge clk); #1;
        end

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
